// File: rtl/dcpu16_pkg.sv
`default_nettype none
// ============================================================================
// dcpu16_pkg : shared phase encodings, opcode constants and decode helpers
// Revision    : 1.0
// ============================================================================
package dcpu16_pkg;

    typedef enum logic [1:0] {
        PHA_EXE = 2'd0,
        PHA_FCH = 2'd1,
        PHA_OPA = 2'd2,
        PHA_OPB = 2'd3
    } pha_t;

    localparam logic [3:0] OP_NB  = 4'h0;
    localparam logic [3:0] OP_SET = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_MUL = 4'h4;
    localparam logic [3:0] OP_DIV = 4'h5;
    localparam logic [3:0] OP_MOD = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_AND = 4'h9;
    localparam logic [3:0] OP_BOR = 4'hA;
    localparam logic [3:0] OP_XOR = 4'hB;
    localparam logic [3:0] OP_IFE = 4'hC;
    localparam logic [3:0] OP_IFN = 4'hD;
    localparam logic [3:0] OP_IFG = 4'hE;
    localparam logic [3:0] OP_IFB = 4'hF;

    localparam logic [5:0] NB_JSR = 6'h01;

    // Operand codes 0x10-0x17 ([nw+reg]), 0x1E ([nw]) and 0x1F (literal nw)
    function automatic logic nw_req(input logic [5:0] code);
        return (code[5:3] == 3'b010) || (code == 6'h1E) || (code == 6'h1F);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcpu16_dec.sv
`default_nettype none
// ============================================================================
// dcpu16_dec : combinational instruction field split and next-word flags
// Revision   : 1.0
// ============================================================================
module dcpu16_dec
    import dcpu16_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic [3:0]  o_opc,
    output logic [5:0]  o_ea_sel,
    output logic [5:0]  o_eb_sel,
    output logic        o_a_nw,
    output logic        o_b_nw,
    output logic        o_is_jsr,
    output logic        o_is_nop,
    output logic        o_is_ifx
);

    logic w_basic;

    always_comb begin
        w_basic  = (i_instr[3:0] != OP_NB);
        o_opc    = i_instr[3:0];
        // Non-basic words carry their sub-opcode in the a-field, not an operand
        o_ea_sel = w_basic ? i_instr[9:4] : 6'h00;
        o_eb_sel = i_instr[15:10];
        o_a_nw   = w_basic && nw_req(i_instr[9:4]);
        o_b_nw   = nw_req(i_instr[15:10]);
        o_is_jsr = !w_basic && (i_instr[9:4] == NB_JSR);
        o_is_nop = !w_basic && (i_instr[9:4] != NB_JSR);
        o_is_ifx = w_basic && (i_instr[3:0] >= OP_IFE);
    end

endmodule
`default_nettype wire

// File: rtl/dcpu16_seq.sv
`default_nettype none
// ============================================================================
// dcpu16_seq : DCPU16 fetch/decode sequencer with IFx skip and PC control
//              Optional DCPU16_PERF_EN adds retired/skipped counters.
// Revision   : 1.0
// ============================================================================
module dcpu16_seq
    import dcpu16_pkg::*;
#(
    parameter logic [15:0] RST_PC = 16'h0000
`ifdef DCPU16_PERF_EN
    ,
    parameter int unsigned PERF_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fch_req,
    output logic [15:0]       fch_adr,
    input  logic              fch_ack,
    input  logic [15:0]       fch_dat,
    input  logic              cc,
    input  logic              pc_ld,
    input  logic [15:0]       pc_dat,
    output logic [3:0]        opc,
    output logic              ena,
    output logic [1:0]        pha,
    output logic [5:0]        ea_sel,
    output logic [5:0]        eb_sel,
    output logic [15:0]       nwa,
    output logic [15:0]       nwb,
    output logic              jsr,
`ifdef DCPU16_PERF_EN
    output logic [PERF_W-1:0] prf_ret,
    output logic [PERF_W-1:0] prf_skp,
`endif
    output logic              skp
);

    pha_t        r_pha;
    pha_t        w_pha_nxt;
    logic        r_req_en;
    logic [15:0] r_pc;
    logic [3:0]  r_opc;
    logic [5:0]  r_ea;
    logic [5:0]  r_eb;
    logic        r_b_nw;
    logic        r_jsr;
    logic        r_nop;
    logic        r_ifx;
    logic [15:0] r_nwa;
    logic [15:0] r_nwb;
    logic        r_skp;
    logic        r_ifx_done;
    logic        w_ack;
    logic        w_exe;

    logic [3:0]  w_d_opc;
    logic [5:0]  w_d_ea;
    logic [5:0]  w_d_eb;
    logic        w_d_a_nw;
    logic        w_d_b_nw;
    logic        w_d_jsr;
    logic        w_d_nop;
    logic        w_d_ifx;

    dcpu16_dec u_dec (
        .i_instr  (fch_dat),
        .o_opc    (w_d_opc),
        .o_ea_sel (w_d_ea),
        .o_eb_sel (w_d_eb),
        .o_a_nw   (w_d_a_nw),
        .o_b_nw   (w_d_b_nw),
        .o_is_jsr (w_d_jsr),
        .o_is_nop (w_d_nop),
        .o_is_ifx (w_d_ifx)
    );

    // Request gate stays low for the first cycle after reset release
    assign fch_req = r_req_en && (r_pha != PHA_EXE);
    assign fch_adr = r_pc;
    assign pha     = r_pha;
    assign opc     = r_opc;
    assign ea_sel  = r_ea;
    assign eb_sel  = r_eb;
    assign nwa     = r_nwa;
    assign nwb     = r_nwb;
    assign skp     = r_skp;
    assign w_ack   = fch_ack && fch_req;
    assign w_exe   = (r_pha == PHA_EXE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pha <= PHA_FCH;
        end else begin
            r_pha <= w_pha_nxt;
        end
    end

    always_comb begin
        w_pha_nxt = r_pha;
        ena       = 1'b0;
        jsr       = 1'b0;
        unique case (r_pha)
            PHA_FCH: begin
                if (w_ack) begin
                    w_pha_nxt = w_d_a_nw ? PHA_OPA : (w_d_b_nw ? PHA_OPB : PHA_EXE);
                end
            end
            PHA_OPA: begin
                if (w_ack) begin
                    w_pha_nxt = r_b_nw ? PHA_OPB : PHA_EXE;
                end
            end
            PHA_OPB: begin
                if (w_ack) begin
                    w_pha_nxt = PHA_EXE;
                end
            end
            default: begin
                w_pha_nxt = PHA_FCH;
                ena       = !r_skp && !r_nop;
                jsr       = !r_skp && r_jsr;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_en   <= 1'b0;
            r_pc       <= RST_PC;
            r_opc      <= 4'h0;
            r_ea       <= 6'h00;
            r_eb       <= 6'h00;
            r_b_nw     <= 1'b0;
            r_jsr      <= 1'b0;
            r_nop      <= 1'b0;
            r_ifx      <= 1'b0;
            r_nwa      <= 16'h0000;
            r_nwb      <= 16'h0000;
            r_skp      <= 1'b0;
            r_ifx_done <= 1'b0;
        end else begin
            r_req_en <= 1'b1;
            if (w_ack) begin
                r_pc <= r_pc + 16'd1;
            end else if (w_exe && pc_ld) begin
                r_pc <= pc_dat;
            end
            if (w_ack && (r_pha == PHA_FCH)) begin
                r_opc      <= w_d_opc;
                r_ea       <= w_d_ea;
                r_eb       <= w_d_eb;
                r_b_nw     <= w_d_b_nw;
                r_jsr      <= w_d_jsr;
                r_nop      <= w_d_nop;
                r_ifx      <= w_d_ifx;
                // cc is valid here: at least one cycle has passed since the IFx EXE
                r_skp      <= r_ifx_done && !cc;
                r_ifx_done <= 1'b0;
            end
            if (w_ack && (r_pha == PHA_OPA)) begin
                r_nwa <= fch_dat;
            end
            if (w_ack && (r_pha == PHA_OPB)) begin
                r_nwb <= fch_dat;
            end
            if (w_exe) begin
                r_ifx_done <= r_ifx && !r_skp;
            end
        end
    end

`ifdef DCPU16_PERF_EN
    localparam logic [PERF_W-1:0] c_one = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] r_prf_ret;
    logic [PERF_W-1:0] r_prf_skp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prf_ret <= '0;
            r_prf_skp <= '0;
        end else begin
            if (ena && (r_prf_ret != '1)) begin
                r_prf_ret <= r_prf_ret + c_one;
            end
            if (w_exe && r_skp && (r_prf_skp != '1)) begin
                r_prf_skp <= r_prf_skp + c_one;
            end
        end
    end

    assign prf_ret = r_prf_ret;
    assign prf_skp = r_prf_skp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcpu16_seq.sv
`default_nettype none
// ============================================================================
// tb_dcpu16_seq : scoreboard bench for dcpu16_seq (RST_PC = 16'hFFFF)
// Revision      : 1.0
// ============================================================================
module tb_dcpu16_seq;

    typedef struct packed {
        logic [3:0]  opc;
        logic        ena;
        logic        jsr;
        logic        skp;
        logic [5:0]  ea;
        logic [5:0]  eb;
        logic [15:0] nwa;
        logic [15:0] nwb;
    } exe_t;

    logic        clk;
    logic        rst;
    logic        fch_req;
    logic [15:0] fch_adr;
    logic        fch_ack;
    logic [15:0] fch_dat;
    logic        cc;
    logic        pc_ld;
    logic [15:0] pc_dat;
    logic [3:0]  opc;
    logic        ena;
    logic [1:0]  pha;
    logic [5:0]  ea_sel;
    logic [5:0]  eb_sel;
    logic [15:0] nwa;
    logic [15:0] nwb;
    logic        jsr;
    logic        skp;

    dcpu16_seq #(.RST_PC(16'hFFFF)) dut (
        .clk     (clk),
        .rst     (rst),
        .fch_req (fch_req),
        .fch_adr (fch_adr),
        .fch_ack (fch_ack),
        .fch_dat (fch_dat),
        .cc      (cc),
        .pc_ld   (pc_ld),
        .pc_dat  (pc_dat),
        .opc     (opc),
        .ena     (ena),
        .pha     (pha),
        .ea_sel  (ea_sel),
        .eb_sel  (eb_sel),
        .nwa     (nwa),
        .nwb     (nwb),
        .jsr     (jsr),
        .skp     (skp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          tid   = 0;
    int          cyc   = 0;
    int          exe_cnt = 0;
    int          lat   = 1;
    bit          spur  = 1'b0;
    exe_t        exe_q[$];
    logic [15:0] adr_q[$];
    int          exe_stamp[$];
    logic [15:0] mem [logic [15:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL t%0d %s: got %h, want %h", tid, name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL t%0d %s: got event, want none", tid, name);
    endtask

    task automatic push_exe(input logic [3:0] o, input logic [5:0] a, input logic [5:0] b,
                            input logic en, input logic j, input logic s,
                            input logic [15:0] wa, input logic [15:0] wb);
        exe_t e;
        e.opc = o; e.ea = a; e.eb = b; e.ena = en; e.jsr = j; e.skp = s;
        e.nwa = wa; e.nwb = wb;
        exe_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: acks after `lat` waiting cycles; optional stray acks when idle
    initial begin
        int wcnt;
        wcnt    = 0;
        fch_ack = 1'b0;
        fch_dat = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst) begin
                fch_ack = 1'b0;
                wcnt    = 0;
            end else if (fch_req) begin
                if (wcnt >= lat) begin
                    fch_ack = 1'b1;
                    fch_dat = mem.exists(fch_adr) ? mem[fch_adr] : 16'h0000;
                    wcnt    = 0;
                end else begin
                    fch_ack = 1'b0;
                    fch_dat = 16'hDEAD;
                    wcnt++;
                end
            end else begin
                fch_ack = spur;
                fch_dat = 16'hBEEF;
                wcnt    = 0;
            end
        end
    end

    // Monitor: pops expected fetch addresses and EXE records
    initial forever begin
        @(negedge clk);
        #1;
        if (rst) begin
            if (fch_req && fch_ack) begin
                if (adr_q.size() == 0) bad("unexpected_fetch");
                else chk("fch_adr", {16'h0, fch_adr}, {16'h0, adr_q.pop_front()});
            end
            if (pha == 2'd0) begin
                exe_cnt++;
                exe_stamp.push_back(cyc);
                if (exe_q.size() == 0) begin
                    bad("unexpected_exe");
                end else begin
                    exe_t e;
                    e = exe_q.pop_front();
                    chk("opc",    {28'h0, opc},    {28'h0, e.opc});
                    chk("ena",    {31'h0, ena},    {31'h0, e.ena});
                    chk("jsr",    {31'h0, jsr},    {31'h0, e.jsr});
                    chk("skp",    {31'h0, skp},    {31'h0, e.skp});
                    chk("ea_sel", {26'h0, ea_sel}, {26'h0, e.ea});
                    chk("eb_sel", {26'h0, eb_sel}, {26'h0, e.eb});
                    chk("nwa",    {16'h0, nwa},    {16'h0, e.nwa});
                    chk("nwb",    {16'h0, nwb},    {16'h0, e.nwb});
                end
            end
        end
    end

    task automatic run(input int id, input int n_exe, input int l, input logic c,
                       input logic ld, input logic [15:0] ld_dat, input bit sp);
        int target;
        tid    = id;
        lat    = l;
        cc     = c;
        pc_ld  = ld;
        pc_dat = ld_dat;
        spur   = sp;
        exe_stamp.delete();
        @(negedge clk);
        rst = 1'b1;
        if (id == 1) begin
            #1 chk("req_release", {31'h0, fch_req}, 32'h0);
            @(posedge clk);
            #1 chk("req_after_release", {31'h0, fch_req}, 32'h1);
        end
        target = exe_cnt + n_exe;
        for (int i = 0; i < 300 && exe_cnt < target; i++) begin
            @(negedge clk);
            #2;
        end
        if (exe_cnt < target) bad("exe_timeout");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        if (adr_q.size() != 0) bad("missing_fetch");
        if (exe_q.size() != 0) bad("missing_exe");
        adr_q.delete();
        exe_q.delete();
    endtask

    initial begin
        rst    = 1'b0;
        cc     = 1'b0;
        pc_ld  = 1'b0;
        pc_dat = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.pha",     {30'h0, pha},     32'h1);
        chk("rst.fch_req", {31'h0, fch_req}, 32'h0);
        chk("rst.fch_adr", {16'h0, fch_adr}, 32'hFFFF);
        chk("rst.ena",     {31'h0, ena},     32'h0);
        chk("rst.opc",     {28'h0, opc},     32'h0);
        chk("rst.sel",     {20'h0, ea_sel, eb_sel}, 32'h0);
        chk("rst.nw",      {nwa, nwb},       32'h0);
        chk("rst.jsr_skp", {30'h0, jsr, skp}, 32'h0);

        // SET A, nw : b literal next-word, PC wraps FFFF -> 0000
        mem.delete();
        mem[16'hFFFF] = 16'h7C01; mem[16'h0000] = 16'h5678;
        adr_q = '{16'hFFFF, 16'h0000};
        push_exe(4'h1, 6'h00, 6'h1F, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h5678);
        run(1, 1, 1, 1'b0, 1'b0, 16'h0000, 1'b0);

        // One-word instr then non-basic NOP; stray acks in EXE must be ignored
        mem.delete();
        mem[16'hFFFF] = 16'h0401; mem[16'h0000] = 16'h0420;
        adr_q = '{16'hFFFF, 16'h0000};
        push_exe(4'h1, 6'h00, 6'h01, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        push_exe(4'h0, 6'h00, 6'h01, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        run(4, 2, 1, 1'b0, 1'b0, 16'h0000, 1'b1);
        if (exe_stamp.size() == 2) chk("exe_gap", exe_stamp[1] - exe_stamp[0], 32'd3);
        else bad("exe_gap_missing");

        // IFE with cc=0 skips the following two-word instr
        mem.delete();
        mem[16'hFFFF] = 16'h040C; mem[16'h0000] = 16'h7C01;
        mem[16'h0001] = 16'h1234; mem[16'h0002] = 16'h0403;
        adr_q = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
        push_exe(4'hC, 6'h00, 6'h01, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        push_exe(4'h1, 6'h00, 6'h1F, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234);
        push_exe(4'h3, 6'h00, 6'h01, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234);
        run(2, 3, 1, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Skipped IFN must not chain-skip
        mem.delete();
        mem[16'hFFFF] = 16'h040C; mem[16'h0000] = 16'h040D; mem[16'h0001] = 16'h0401;
        adr_q = '{16'hFFFF, 16'h0000, 16'h0001};
        push_exe(4'hC, 6'h00, 6'h01, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        push_exe(4'hD, 6'h00, 6'h01, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        push_exe(4'h1, 6'h00, 6'h01, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        run(8, 3, 1, 1'b0, 1'b0, 16'h0000, 1'b0);

        // IFE taken (cc=1), zero-wait memory
        mem.delete();
        mem[16'hFFFF] = 16'h040C; mem[16'h0000] = 16'h7C01;
        mem[16'h0001] = 16'h1234; mem[16'h0002] = 16'h0403;
        adr_q = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
        push_exe(4'hC, 6'h00, 6'h01, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        push_exe(4'h1, 6'h00, 6'h1F, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234);
        push_exe(4'h3, 6'h00, 6'h01, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234);
        run(3, 3, 0, 1'b1, 1'b0, 16'h0000, 1'b0);

        // JSR: pc_ld held high throughout, only the EXE cycle may load PC
        mem.delete();
        mem[16'hFFFF] = 16'h7C10; mem[16'h0000] = 16'h0040; mem[16'h0040] = 16'h0401;
        adr_q = '{16'hFFFF, 16'h0000, 16'h0040};
        push_exe(4'h0, 6'h00, 6'h1F, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0040);
        push_exe(4'h1, 6'h00, 6'h01, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0040);
        run(5, 2, 1, 1'b1, 1'b1, 16'h0040, 1'b0);

        // Both operands with next-words, then a-only next-word
        mem.delete();
        mem[16'hFFFF] = 16'h7DE1; mem[16'h0000] = 16'h1000; mem[16'h0001] = 16'h0020;
        mem[16'h0002] = 16'h0501; mem[16'h0003] = 16'h00AA;
        adr_q = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
        push_exe(4'h1, 6'h1E, 6'h1F, 1'b1, 1'b0, 1'b0, 16'h1000, 16'h0020);
        push_exe(4'h1, 6'h10, 6'h01, 1'b1, 1'b0, 1'b0, 16'h00AA, 16'h0020);
        run(7, 2, 2, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Reset asserted while waiting on the OPB fetch
        tid   = 6;
        lat   = 4;
        cc    = 1'b0;
        pc_ld = 1'b0;
        spur  = 1'b0;
        mem.delete();
        mem[16'hFFFF] = 16'h7C01;
        adr_q = '{16'hFFFF};
        @(negedge clk);
        rst = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                #2;
                if (pha == 2'd3) seen = 1'b1;
            end
            if (!seen) bad("opb_timeout");
        end
        repeat (2) @(negedge clk);
        #2;
        chk("opb.req_before", {31'h0, fch_req}, 32'h1);
        rst = 1'b0;
        #1;
        chk("opb.req_async",  {31'h0, fch_req}, 32'h0);
        chk("opb.pha",        {30'h0, pha},     32'h1);
        chk("opb.fch_adr",    {16'h0, fch_adr}, 32'hFFFF);
        repeat (2) @(negedge clk);
        if (adr_q.size() != 0) bad("missing_fetch");
        if (exe_q.size() != 0) bad("missing_exe");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
